sos_coef_bank: RTL

- Upstream coefficient store for the cascaded biquad (SOS) filter chain; drives b0/b1/b2/a1/a2 of every section.
- Double-buffered: host writes go to a shadow bank; a commit copies shadow to active only on a sample-frame boundary, so no section ever sees a half-updated coefficient set.
- Sits between the configuration bus and the SOS stage instances.

---
 rtl/sos_pkg.sv | 47 ++++
 rtl/sos_coef_regs.sv | 54 +++++
 rtl/sos_coef_bank.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sos_pkg.sv
// Shared types and constants for the SOS coefficient bank: Q2.22 width, unity,
// coefficient index enum, per-section coefficient struct and the bank FSM states.
package sos_pkg;

    localparam int COEF_W   = 24;
    localparam int NUM_COEF = 5;
    localparam logic [COEF_W-1:0] COEF_UNITY = 24'h400000;

    typedef enum logic [2:0] {
        COEF_B0 = 3'd0,
        COEF_B1 = 3'd1,
        COEF_B2 = 3'd2,
        COEF_A1 = 3'd3,
        COEF_A2 = 3'd4
    } coef_idx_e;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } bank_state_e;

    typedef struct packed {
        logic [COEF_W-1:0] b0;
        logic [COEF_W-1:0] b1;
        logic [COEF_W-1:0] b2;
        logic [COEF_W-1:0] a1;
        logic [COEF_W-1:0] a2;
    } sec_coef_t;

    // A section that passes its input straight through: b0 = 1.0, everything else 0.
    localparam sec_coef_t COEF_PASSTHROUGH = '{b0: COEF_UNITY, b1: '0, b2: '0, a1: '0, a2: '0};

    function automatic logic [COEF_W-1:0] coef_select(input sec_coef_t s, input logic [2:0] idx);
        logic [COEF_W-1:0] v;
        v = '0;
        case (coef_idx_e'(idx))
            COEF_B0: v = s.b0;
            COEF_B1: v = s.b1;
            COEF_B2: v = s.b2;
            COEF_A1: v = s.a1;
            COEF_A2: v = s.a2;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/sos_coef_regs.sv
// One biquad section's shadow and active coefficient registers.
// Optional COEF_READBACK_EN exposes the shadow set for host readback.
module sos_coef_regs
    import sos_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [2:0]        wr_coef_idx_i,
    input  logic [COEF_W-1:0] wr_data_i,
    input  logic              copy_en_i,
`ifdef COEF_READBACK_EN
    output sec_coef_t         shadow_o,
`endif
    output sec_coef_t         active_o
);

    sec_coef_t shadow_q;
    sec_coef_t shadow_d;
    sec_coef_t active_q;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            case (coef_idx_e'(wr_coef_idx_i))
                COEF_B0: shadow_d.b0 = wr_data_i;
                COEF_B1: shadow_d.b1 = wr_data_i;
                COEF_B2: shadow_d.b2 = wr_data_i;
                COEF_A1: shadow_d.a1 = wr_data_i;
                COEF_A2: shadow_d.a2 = wr_data_i;
                default: ;
            endcase
        end
    end

    // Copy samples shadow_q, so a write landing on the copy edge stays in shadow only.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= COEF_PASSTHROUGH;
            active_q <= COEF_PASSTHROUGH;
        end else begin
            shadow_q <= shadow_d;
            if (copy_en_i) begin
                active_q <= shadow_q;
            end
        end
    end

`ifdef COEF_READBACK_EN
    assign shadow_o = shadow_q;
`endif
    assign active_o = active_q;

endmodule

// File: rtl/sos_coef_bank.sv
// Double-buffered coefficient store for the SOS cascade; commits take effect only on frame_sync.
// Define COEF_READBACK_EN to add the registered host readback port.
module sos_coef_bank #(
    parameter int NUM_SEC   = 4,
    parameter int COEF_W    = 24,
    parameter int SEC_IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_wr_en,
    input  logic [SEC_IDX_W-1:0]      cfg_sec_idx,
    input  logic [2:0]                cfg_coef_idx,
    input  logic [COEF_W-1:0]         cfg_wdata,
    input  logic                      cfg_commit,
    input  logic                      frame_sync,
    output logic [NUM_SEC*COEF_W-1:0] coef_b0,
    output logic [NUM_SEC*COEF_W-1:0] coef_b1,
    output logic [NUM_SEC*COEF_W-1:0] coef_b2,
    output logic [NUM_SEC*COEF_W-1:0] coef_a1,
    output logic [NUM_SEC*COEF_W-1:0] coef_a2,
    output logic                      commit_pending,
    output logic                      commit_done,
    output logic                      cfg_err
`ifdef COEF_READBACK_EN
    ,
    input  logic                      cfg_rd_en,
    input  logic                      cfg_rd_sel,
    output logic [COEF_W-1:0]         cfg_rdata
`endif
);

    import sos_pkg::*;

    bank_state_e state_q;
    bank_state_e state_d;
    logic        commitDone_q;
    logic        cfgErr_q;
    logic        copyEn;
    logic        idxLegal;
    sec_coef_t   active [NUM_SEC];

    assign idxLegal = (32'(cfg_sec_idx) < NUM_SEC) && (cfg_coef_idx <= 3'(COEF_A2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A commit arriving with frame_sync in IDLE waits for the next sync; extra commits merge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cfg_commit) state_d = ST_PENDING;
            ST_PENDING: if (frame_sync) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        copyEn         = (state_q == ST_PENDING) && frame_sync;
        commit_pending = (state_q == ST_PENDING);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commitDone_q <= 1'b0;
            cfgErr_q     <= 1'b0;
        end else begin
            commitDone_q <= copyEn;
            if (cfg_wr_en && !idxLegal) begin
                cfgErr_q <= 1'b1;
            end
        end
    end

    assign commit_done = commitDone_q;
    assign cfg_err     = cfgErr_q;

`ifdef COEF_READBACK_EN
    sec_coef_t shadow [NUM_SEC];
`endif

    for (genvar k = 0; k < NUM_SEC; k++) begin : g_sec
        logic wrSec;
        assign wrSec = cfg_wr_en && idxLegal && (cfg_sec_idx == SEC_IDX_W'(k));

        sos_coef_regs u_regs (
            .clk           (clk),
            .rst           (rst),
            .wr_en_i       (wrSec),
            .wr_coef_idx_i (cfg_coef_idx),
            .wr_data_i     (cfg_wdata),
            .copy_en_i     (copyEn),
`ifdef COEF_READBACK_EN
            .shadow_o      (shadow[k]),
`endif
            .active_o      (active[k])
        );

        assign coef_b0[k*COEF_W +: COEF_W] = active[k].b0;
        assign coef_b1[k*COEF_W +: COEF_W] = active[k].b1;
        assign coef_b2[k*COEF_W +: COEF_W] = active[k].b2;
        assign coef_a1[k*COEF_W +: COEF_W] = active[k].a1;
        assign coef_a2[k*COEF_W +: COEF_W] = active[k].a2;
    end

`ifdef COEF_READBACK_EN
    sec_coef_t         rdSet;
    logic [COEF_W-1:0] rdata_q;
    logic [COEF_W-1:0] rdata_d;

    always_comb begin
        rdSet = '0;
        for (int k = 0; k < NUM_SEC; k++) begin
            if (cfg_sec_idx == SEC_IDX_W'(k)) begin
                rdSet = cfg_rd_sel ? active[k] : shadow[k];
            end
        end
    end

    // Reads see the registers before this edge's write or copy lands.
    always_comb begin
        rdata_d = rdata_q;
        if (cfg_rd_en) begin
            rdata_d = idxLegal ? coef_select(rdSet, cfg_coef_idx) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign cfg_rdata = rdata_q;
`endif

endmodule
